referee_merge: RTL and testbench
================================

REFEREE_MERGE -- requirements
Module: referee_merge

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 12, the word width of every data port.
REQ-002 SHALL have parameter NUM_IN, default 4, the number of source FIFOs; fixed at 4 in this revision.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port almost_empty_signal, input, 4 bits: bit i high means source FIFO i is not safe to pop.
REQ-007 SHALL have port data_in0..data_in3, input, LINE_SIZE each: head-of-FIFO data of sources 0..3.
REQ-008 SHALL have port almost_full_signal, input, 1 bit: sink FIFO cannot accept new pops' data.
REQ-009 SHALL have port pop_signal, output, 4 bits: one-hot pop to source FIFO i.
REQ-010 SHALL have port push_signal, output, 1 bit: write strobe to sink FIFO.
REQ-011 SHALL have port data_out, output, LINE_SIZE: word written to sink FIFO, valid when push_signal=1.

Function
REQ-012 SHALL be eligible for source i in a cycle iff almost_empty_signal[i]=0, almost_full_signal=0 and state=ACTIVE.
REQ-013 SHALL assert at most one pop_signal bit per cycle (one-hot or zero).
REQ-014 SHALL register the granted index g at the cycle-N pop and capture data_in_g at the end of cycle N+1.
REQ-015 SHALL drive push_signal=1 and data_out=captured word in cycle N+2 (fixed 2-cycle pop-to-push latency).
REQ-016 SHALL support back-to-back pops every cycle, giving one push per cycle in steady state.
REQ-017 SHALL never drop or duplicate a popped word; words in flight when almost_full_signal rises SHALL still be pushed (sink margin >= 2 words).
REQ-018 SHALL use FSM states IDLE, ACTIVE, HOLD.
REQ-019 IDLE->ACTIVE SHALL occur the first cycle after reset deasserts; IDLE issues no pops.
REQ-020 ACTIVE->HOLD SHALL occur when almost_full_signal=1; HOLD->ACTIVE when almost_full_signal=0.
REQ-021 HOLD SHALL issue no pops but SHALL drain the in-flight pipeline.
REQ-022 SHALL issue no pop when all sources are almost-empty; push_signal follows the pipeline only.
REQ-023 SHALL leave data_out holding its last value when push_signal=0.

Reset
REQ-024 SHALL, with reset=1 at a rising edge, set state=IDLE, pop_signal=4'b0000, push_signal=0, data_out=0, pipeline valid bits=0, and round-robin pointer=0.
REQ-025 SHALL discard in-flight words when reset is asserted mid-operation; no push in the cycle after reset.

Configuration
REQ-026 SHALL support macro REFEREE_MERGE_RR_EN.
REQ-027 With REFEREE_MERGE_RR_EN defined, SHALL grant round-robin: search starts at the index after the last grant and wraps 3->0.
REQ-028 Without REFEREE_MERGE_RR_EN, SHALL grant fixed priority, source 0 highest, source 3 lowest.

Structure
REQ-029 SHALL take LINE_SIZE, NUM_IN and FSM state encodings (IDLE=2'd0, ACTIVE=2'd1, HOLD=2'd2) from the shared referee package/include.
REQ-030 SHALL place grant selection in one sub-module, referee_merge_arb (inputs: eligibility vector, pointer; output: one-hot grant).

Verification
REQ-031 Reset, then all almost_empty=0, almost_full=0, RR on -> pops 0001,0010,0100,1000,0001; push from cycle N+2 each cycle with data_in0..3 values 0x0A1,0x0B2,0x0C3,0x0D4 in order.
REQ-032 Priority build, almost_empty=4'b1100 -> pop_signal=0001 every cycle; data_out=data_in0 two cycles later.
REQ-033 Streaming, almost_full rises at cycle 10 -> no pop from cycle 10, pushes at cycles 10 and 11 then push=0; deassert at 15 -> pop at 16, push at 18.
REQ-034 almost_empty=4'b1111 for 8 cycles -> pop_signal=0, push_signal=0 after pipeline drains.
REQ-035 Reset asserted one cycle after a pop -> no push in following cycle; data_out=0; state IDLE.
REQ-036 Only source 2 eligible, RR on, pointer at 3 -> wrap search grants 0100.

Source files
------------

// File: rtl/referee_merge_pkg.sv
// Shared types and constants for the referee merge unit.
// Holds widths, FSM encodings and a one-hot to index helper.
package referee_merge_pkg;

  localparam int REF_LINE_SIZE = 12;
  localparam int REF_NUM_IN    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_idx(
    input logic [3:0] oh
  );
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      oh[0]:   idx = 2'd0;
      oh[1]:   idx = 2'd1;
      oh[2]:   idx = 2'd2;
      oh[3]:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/referee_merge_arb.sv
// Grant selector for the referee merge; REFEREE_MERGE_RR_EN picks
// round-robin from ptr, otherwise fixed priority with source 0 highest.
module referee_merge_arb
  import referee_merge_pkg::*;
(
  input  logic [3:0] elig,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);

`ifdef REFEREE_MERGE_RR_EN
  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;

  assign unused_ptr = ^ptr;

  // Isolate the lowest set bit.
  always_comb begin
    grant = elig & (~elig + 4'd1);
  end
`endif

endmodule

// File: rtl/referee_merge.sv
// Merges four source FIFOs into one sink with a 2-cycle pop-to-push pipe.
// Build option REFEREE_MERGE_RR_EN selects round-robin granting.
module referee_merge
  import referee_merge_pkg::*;
#(
  parameter int LINE_SIZE = REF_LINE_SIZE,
  parameter int NUM_IN    = REF_NUM_IN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IN-1:0]    almost_empty_signal,
  input  logic [LINE_SIZE-1:0] data_in0,
  input  logic [LINE_SIZE-1:0] data_in1,
  input  logic [LINE_SIZE-1:0] data_in2,
  input  logic [LINE_SIZE-1:0] data_in3,
  input  logic                 almost_full_signal,
  output logic [NUM_IN-1:0]    pop_signal,
  output logic                 push_signal,
  output logic [LINE_SIZE-1:0] data_out
);

  state_t               state_q;
  state_t               state_d;
  logic                 can_pop;
  logic [NUM_IN-1:0]    elig;
  logic [NUM_IN-1:0]    grant;
  logic [1:0]           g_idx;
  logic [1:0]           ptr_q;
  logic                 s1_valid;
  logic [1:0]           s1_idx;
  logic [LINE_SIZE-1:0] sel_data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ACTIVE;
      ACTIVE:  if (almost_full_signal) state_d = HOLD;
      HOLD:    if (!almost_full_signal) state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  // No pop in a reset cycle: the word would be lost with the pipe.
  always_comb begin
    can_pop = (state_q == ACTIVE) && !almost_full_signal && !reset;
    elig    = can_pop ? ~almost_empty_signal : '0;
  end

  referee_merge_arb u_arb (
    .elig  (elig),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    pop_signal = grant;
    g_idx      = onehot_idx(grant);
  end

  always_comb begin
    sel_data = data_in0;
    unique case (s1_idx)
      2'd0: sel_data = data_in0;
      2'd1: sel_data = data_in1;
      2'd2: sel_data = data_in2;
      2'd3: sel_data = data_in3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      s1_valid    <= 1'b0;
      s1_idx      <= 2'd0;
      push_signal <= 1'b0;
      data_out    <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid    <= |grant;
      push_signal <= s1_valid;
      if (|grant) begin
        s1_idx <= g_idx;
        ptr_q  <= g_idx + 2'd1;
      end
      if (s1_valid) begin
        data_out <= sel_data;
      end
    end
  end

`ifndef SYNTHESIS
  a_pop_onehot: assert property (
    @(posedge clk) $onehot0(pop_signal)
  );
  a_no_pop_full: assert property (
    @(posedge clk) almost_full_signal |-> (pop_signal == '0)
  );
`endif

endmodule

// File: tb/tb_referee_merge.sv
// Bench for referee_merge: scoreboard model plus literal checks.
// Compile with REFEREE_MERGE_RR_EN to match a round-robin build.
module tb_referee_merge;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   ae;
  logic         af;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   pop_signal;
  logic         push_signal;
  logic [W-1:0] data_out;

  referee_merge dut (
    .clk                 (clk),
    .reset               (reset),
    .almost_empty_signal (ae),
    .data_in0            (d0),
    .data_in1            (d1),
    .data_in2            (d2),
    .data_in3            (d3),
    .almost_full_signal  (af),
    .pop_signal          (pop_signal),
    .push_signal         (push_signal),
    .data_out            (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    int           idx;
    logic [W-1:0] data;
  } ent_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  ent_t         q[$];
  int           cyc_no = 0;
  int           t_rel = 0;
  bit           af_prev = 0;
  int           ptr = 0;
  logic [W-1:0] last = '0;
  logic [W-1:0] din[4];
  logic [3:0]   obs_pop;
  logic         obs_push;
  logic [W-1:0] obs_data;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h",
               nm, cyc_no, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] el, input int p);
`ifdef REFEREE_MERGE_RR_EN
    for (int k = 0; k < 4; k++)
      if (el[(p + k) % 4]) return (p + k) % 4;
`else
    for (int i = 0; i < 4; i++)
      if (el[i]) return i;
`endif
    return -1;
  endfunction

  // One clock cycle: check registered outputs, drive, check pop.
  task automatic cyc(input bit r, input logic [3:0] a, input bit f);
    logic [3:0] el;
    logic [3:0] ep;
    bit         allowed;
    int         g;
    @(posedge clk);
    #1;
    obs_push = push_signal;
    obs_data = data_out;
    if (q.size() > 0 && q[0].due == cyc_no) begin
      chk("push", push_signal, 1);
      chk("data_out", data_out, q[0].data);
      last = q[0].data;
      void'(q.pop_front());
    end else begin
      chk("push_idle", push_signal, 0);
      chk("data_hold", data_out, last);
    end
    reset = r;
    ae = a;
    af = f;
    d0 = din[0];
    d1 = din[1];
    d2 = din[2];
    d3 = din[3];
    #1;
    obs_pop = pop_signal;
    allowed = !r && t_rel >= 1 && (t_rel == 1 || !af_prev) && !f;
    el = allowed ? ~a : 4'b0000;
    g = pick(el, ptr);
    ep = (g < 0) ? 4'b0000 : 4'(1 << g);
    chk("pop", pop_signal, ep);
    foreach (q[i])
      if (q[i].due == cyc_no + 1) q[i].data = din[q[i].idx];
    if (g >= 0) q.push_back('{cyc_no + 2, g, '0});
    if (r) begin
      q.delete();
      last = '0;
      t_rel = 0;
      ptr = 0;
      af_prev = 0;
    end else begin
      if (t_rel < 2) t_rel++;
      af_prev = f;
      if (g >= 0) ptr = (g + 1) % 4;
    end
    cyc_no++;
  endtask

`ifdef REFEREE_MERGE_RR_EN
  logic [3:0]   lit_ae = 4'b0000;
  logic [3:0]   lit_pop[9] = '{0, 1, 2, 4, 8, 1, 2, 4, 8};
  logic [W-1:0] lit_dat[9] = '{0, 0, 0, 'h0A1, 'h0B2, 'h0C3,
                               'h0D4, 'h0A1, 'h0B2};
`else
  logic [3:0]   lit_ae = 4'b1100;
  logic [3:0]   lit_pop[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [W-1:0] lit_dat[9] = '{0, 0, 0, 'h0A1, 'h0A1, 'h0A1,
                               'h0A1, 'h0A1, 'h0A1};
`endif

  initial begin
    reset = 1'b1;
    ae = 4'hF;
    af = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    d0 = '0;
    d1 = '0;
    d2 = '0;
    d3 = '0;
    repeat (2) @(posedge clk);

    // Ordered grants and data path with fixed head words.
    din[0] = 'h0A1;
    din[1] = 'h0B2;
    din[2] = 'h0C3;
    din[3] = 'h0D4;
    for (int k = 0; k < 9; k++) begin
      cyc(0, lit_ae, 0);
      chk("lit_pop_seq", obs_pop, lit_pop[k]);
      if (k >= 3) begin
        chk("lit_push_seq", obs_push, 1);
        chk("lit_data_seq", obs_data, lit_dat[k]);
      end
    end

    // Only source 2 eligible, pointer wrapped past it.
    cyc(1, 4'hF, 0);
    cyc(0, 4'hF, 0);
    cyc(0, 4'b1011, 0);
    chk("lit_src2_a", obs_pop, 4'b0100);
    cyc(0, 4'b1011, 0);
    chk("lit_src2_wrap", obs_pop, 4'b0100);

    // All sources almost empty.
    for (int k = 0; k < 8; k++) begin
      cyc(0, 4'hF, 0);
      chk("lit_empty_pop", obs_pop, 0);
      if (k >= 2) chk("lit_empty_push", obs_push, 0);
    end

    // Back-pressure window in a stream.
    cyc(1, 4'h0, 0);
    for (int k = 0; k < 21; k++) begin
      for (int i = 0; i < 4; i++) din[i] = W'($urandom);
      cyc(0, 4'h0, (k >= 10 && k < 15));
      if (k >= 10 && k <= 15) chk("lit_full_pop", obs_pop, 0);
      if (k == 16) chk("lit_resume_pop", obs_pop != 0, 1);
      if (k == 10 || k == 11) chk("lit_drain_push", obs_push, 1);
      if (k >= 12 && k <= 17) chk("lit_hold_push", obs_push, 0);
      if (k == 18) chk("lit_resume_push", obs_push, 1);
    end

    // Reset one cycle after a pop.
    cyc(1, 4'h0, 0);
    cyc(0, 4'h0, 0);
    cyc(0, 4'h0, 0);
    chk("lit_pre_rst_pop", obs_pop != 0, 1);
    cyc(1, 4'h0, 0);
    cyc(0, 4'h0, 0);
    chk("lit_rst_push", obs_push, 0);
    chk("lit_rst_data", obs_data, 0);
    chk("lit_rst_idle_pop", obs_pop, 0);

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 4; i++) din[i] = W'($urandom);
      cyc(($urandom % 100) < 2,
          ($urandom % 4 == 0) ? 4'hF : 4'($urandom),
          ($urandom % 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
